// File: rtl/multi_chan_pass_monitor_if.sv
// multi_chan_pass_monitor_if: control strobes and status outputs of the pass monitor
interface multi_chan_pass_monitor_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 clear;
    logic [NCH-1:0]       inc;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH-1:0]       done_ch;
    logic                 busy;
    logic                 passed;
    logic                 failed;

    modport master (output start, clear, inc, input count, done_ch, busy, passed, failed);
    modport slave  (input start, clear, inc, output count, done_ch, busy, passed, failed);
endinterface

// File: rtl/multi_chan_pass_monitor.sv
// multi_chan_pass_monitor: per-channel event counters with pass-on-target and watchdog fail
module multi_chan_pass_monitor #(
    parameter int          NCH      = 2,
    parameter int          WIDTH    = 32,
    parameter int unsigned TARGET   = 5,
    parameter int unsigned TIMEOUT  = 1000,
    parameter bit          SATURATE = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    multi_chan_pass_monitor_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    logic [1:0]     state;
    logic [31:0]    wd;
    logic [NCH-1:0] done;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] cnt_nxt;
        logic             d;
        assign cnt_nxt = (&cnt) ? (SATURATE ? cnt : '0) : cnt + 1'b1;
        // done latches on the TARGET-1 -> TARGET step and survives later wraps
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                d   <= 1'b0;
            end else if (bus.clear) begin
                cnt <= '0;
                d   <= 1'b0;
            end else if (state == RUN && bus.inc[i]) begin
                cnt <= cnt_nxt;
                if (cnt == WIDTH'(TARGET - 1)) d <= 1'b1;
            end
        end
        assign bus.count[i*WIDTH +: WIDTH] = cnt;
        assign done[i] = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wd    <= '0;
        end else if (bus.clear) begin
            state <= IDLE;
            wd    <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                state <= RUN;
                wd    <= '0;
            end
        end else if (state == RUN) begin
            wd    <= wd + 32'd1;
            state <= (&done) ? PASS : (wd == 32'(TIMEOUT - 1)) ? FAIL : RUN;
        end
    end

    assign bus.done_ch = done;
    assign bus.busy    = state == RUN;
    assign bus.passed  = state == PASS;
    assign bus.failed  = state == FAIL;
endmodule

// File: tb/tb_multi_chan_pass_monitor.sv
// tb_multi_chan_pass_monitor: scoreboard bench over three monitors sharing one stimulus stream
module tb_multi_chan_pass_monitor;
    localparam int TGT = 5;
    localparam int TO  = 20;
    localparam int W[3]   = '{32, 3, 3};
    localparam bit SAT[3] = '{1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] dn;
        longint     c0;
        longint     c1;
        int         wd;
    } mdl_t;

    typedef struct {
        string       tag;
        int          d;
        logic [68:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] inc = 2'b00;
    int         errors = 0;
    int         checks = 0;
    mdl_t       m[3];
    sb_t        sbq[$];

    always #5 clk = ~clk;

    multi_chan_pass_monitor_if #(.NCH(2), .WIDTH(32)) if0 ();
    multi_chan_pass_monitor_if #(.NCH(2), .WIDTH(3))  if1 ();
    multi_chan_pass_monitor_if #(.NCH(2), .WIDTH(3))  if2 ();

    assign if0.start = start;
    assign if0.clear = clear;
    assign if0.inc   = inc;
    assign if1.start = start;
    assign if1.clear = clear;
    assign if1.inc   = inc;
    assign if2.start = start;
    assign if2.clear = clear;
    assign if2.inc   = inc;

    multi_chan_pass_monitor #(.NCH(2), .WIDTH(32), .TARGET(TGT), .TIMEOUT(TO), .SATURATE(1'b1))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    multi_chan_pass_monitor #(.NCH(2), .WIDTH(3), .TARGET(TGT), .TIMEOUT(TO), .SATURATE(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    multi_chan_pass_monitor #(.NCH(2), .WIDTH(3), .TARGET(TGT), .TIMEOUT(TO), .SATURATE(1'b0))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [68:0] obs(input int d);
        case (d)
            0:       return {if0.failed, if0.passed, if0.busy, if0.done_ch, if0.count[63:32], if0.count[31:0]};
            1:       return {if1.failed, if1.passed, if1.busy, if1.done_ch, 29'd0, if1.count[5:3], 29'd0, if1.count[2:0]};
            default: return {if2.failed, if2.passed, if2.busy, if2.done_ch, 29'd0, if2.count[5:3], 29'd0, if2.count[2:0]};
        endcase
    endfunction

    function automatic logic [68:0] pk(input mdl_t s);
        return {s.st == 2'd3, s.st == 2'd2, s.st == 2'd1, s.dn, s.c1[31:0], s.c0[31:0]};
    endfunction

    function automatic longint bump(input longint c, input longint mx, input bit sat);
        return (c == mx) ? (sat ? mx : 64'd0) : c + 1;
    endfunction

    task automatic step(input int d);
        mdl_t   o = m[d];
        mdl_t   n = m[d];
        longint mx = (longint'(1) << W[d]) - 1;
        if (clear) n = '0;
        else if (o.st == 2'd0) begin
            if (start) begin
                n.st = 2'd1;
                n.wd = 0;
            end
        end else if (o.st == 2'd1) begin
            if (inc[0]) n.c0 = bump(o.c0, mx, SAT[d]);
            if (inc[1]) n.c1 = bump(o.c1, mx, SAT[d]);
            if (inc[0] && n.c0 == TGT) n.dn[0] = 1'b1;
            if (inc[1] && n.c1 == TGT) n.dn[1] = 1'b1;
            n.wd = o.wd + 1;
            if (o.dn == 2'b11) n.st = 2'd2;
            else if (o.wd == TO - 1) n.st = 2'd3;
        end
        m[d] = n;
    endtask

    task automatic sb_push(input string tag);
        for (int d = 0; d < 3; d++) sbq.push_back('{tag, d, pk(m[d])});
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("%s_d%0d", e.tag, e.d), obs(e.d), e.exp);
        end
    endtask

    task automatic cyc(input string tag, input logic s, input logic c, input logic [1:0] i);
        @(negedge clk);
        start = s;
        clear = c;
        inc   = i;
        for (int d = 0; d < 3; d++) step(d);
        sb_push(tag);
        @(posedge clk);
        #1;
        sb_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 3; d++) m[d] = '0;
        @(posedge clk);
        #1;
        sb_push("reset");
        sb_drain();
        @(negedge clk);
        reset = 1'b0;

        cyc("t1_start", 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 5; k++) cyc("t1_inc", 1'b0, 1'b0, 2'b11);
        check("t1_done", 69'(if0.done_ch), 69'(2'b11));
        check("t1_nopass_yet", 69'(if0.passed), 69'(1'b0));
        cyc("t1_pass", 1'b0, 1'b0, 2'b00);
        check("t1_passed", 69'(if0.passed), 69'(1'b1));
        for (int k = 0; k < 3; k++) cyc("t1_frozen", 1'b1, 1'b0, 2'b11);
        check("t1_count", 69'(if0.count), 69'({32'd5, 32'd5}));
        check("t1_nofail", 69'(if0.failed), 69'(1'b0));

        cyc("t6_clr_start", 1'b1, 1'b1, 2'b00);
        check("t6_idle", 69'({if0.busy, if0.passed, if0.count}), 69'(0));
        cyc("t6_restart", 1'b1, 1'b0, 2'b00);
        check("t6_run", 69'(if0.busy), 69'(1'b1));

        for (int k = 0; k < 14; k++) begin
            cyc("t2_mix", 1'b0, 1'b0, {k % 3 == 0, 1'b1});
            if (k == 4) check("t2_d01", 69'(if0.done_ch), 69'(2'b01));
            if (k == 12) check("t2_d11", 69'({if0.done_ch, if0.passed}), 69'(3'b110));
        end
        check("t2_pass", 69'(if0.passed), 69'(1'b1));
        check("t2_c0_gt5", 69'(if0.count[31:0] > 32'd5), 69'(1'b1));

        cyc("t3_clear", 1'b0, 1'b1, 2'b00);
        cyc("t3_start", 1'b1, 1'b0, 2'b00);
        for (int n = 2; n <= 11; n++) cyc("t3_inc0", 1'b0, 1'b0, 2'b01);
        check("t4_sat", 69'({if1.done_ch[0], if1.count[2:0]}), 69'(4'b1111));
        check("t4_wrap", 69'({if2.done_ch[0], if2.count[2:0]}), 69'(4'b1010));
        for (int n = 12; n <= 20; n++) cyc("t3_wait", 1'b0, 1'b0, 2'b00);
        check("t3_prefail", 69'(if0.failed), 69'(1'b0));
        cyc("t3_edge21", 1'b0, 1'b0, 2'b00);
        check("t3_fail", 69'({if0.failed, if0.passed, if0.done_ch}), 69'(4'b1001));

        cyc("t5_clear", 1'b0, 1'b1, 2'b00);
        cyc("t5_start", 1'b1, 1'b0, 2'b00);
        cyc("t5_inc", 1'b0, 1'b0, 2'b11);
        cyc("t5_inc", 1'b0, 1'b0, 2'b11);
        cyc("t5_inc", 1'b0, 1'b0, 2'b10);
        check("t5_pre", 69'(if0.count), 69'({32'd3, 32'd2}));
        #2;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) m[d] = '0;
        #1;
        sb_push("t5_arst");
        sb_drain();
        #1;
        reset = 1'b0;
        cyc("t5_ignored", 1'b0, 1'b0, 2'b11);
        cyc("t5_ignored", 1'b0, 1'b0, 2'b11);
        check("t5_idle", 69'({if0.busy, if0.count}), 69'(0));
        cyc("t5_restart", 1'b1, 1'b0, 2'b00);
        cyc("t5_count", 1'b0, 1'b0, 2'b11);
        check("t5_after", 69'(if0.count), 69'({32'd1, 32'd1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_chan_pass_monitor.md
Name: multi_chan_pass_monitor

Overview:
- Parametrised, multi-channel successor to the simple self-checking counter in the test harness.
- Counts per-channel increment events and declares pass once every channel reaches a programmed target.
- Declares fail if a cycle-count watchdog expires before all channels finish.
- Sits at the top of simulation testbenches: drives the harness pass/fail outputs that the C++ wrapper polls to end a run.

Parameters:
- NCH, 2, number of independent counting channels (1..16)
- WIDTH, 32, width of each channel counter (2..32)
- TARGET, 5, count value at which a channel is done (1 <= TARGET <= 2^WIDTH-1)
- TIMEOUT, 1000, RUN-state cycle budget before failure (>= 1, < 2^32)
- SATURATE, 1, 1 = counters hold at 2^WIDTH-1; 0 = counters wrap to 0

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; IDLE -> RUN
- clear  input  1  synchronous clear to IDLE from any state
- inc  input  NCH  per-channel increment strobe, sampled only in RUN
- count  output  NCH*WIDTH  channel counters; channel i at bits [i*WIDTH +: WIDTH]
- done_ch  output  NCH  sticky per-channel done flags
- busy  output  1  high while in RUN
- passed  output  1  high while in PASS
- failed  output  1  high while in FAIL

Behaviour:
- Reset (async, active-high): state = IDLE; count = 0; done_ch = 0; watchdog = 0; busy, passed and failed = 0. Effective immediately, including mid-RUN. Outputs stay at these values until the first posedge after reset deasserts.
- State machine has four states: IDLE, RUN, PASS, FAIL. All outputs are registered or decoded directly from the state register, with no combinational path from inputs.
- clear (sync) has the highest priority in every state:
  - next state = IDLE;
  - counters, done_ch and watchdog are zeroed.
  - clear and start asserted on the same cycle: clear wins and the FSM stays in IDLE.
- IDLE:
  - inc is ignored.
  - start = 1 moves to RUN on the next edge; watchdog is loaded with 0.
- RUN, per channel i, when inc[i] = 1:
  - count_i increments by 1.
  - At 2^WIDTH-1 it holds if SATURATE = 1, or wraps to 0 if SATURATE = 0.
  - done_ch[i] sets on the same edge count_i goes from TARGET-1 to TARGET.
  - done_ch[i] is sticky: a later wrap does not clear it.
  - Counting continues after done.
- RUN, watchdog: increments by 1 every RUN cycle. Width is 32 bits; it never wraps, since TIMEOUT < 2^32.
- RUN, transitions (evaluated on registered values):
  - if &done_ch = 1, next state = PASS;
  - else if watchdog = TIMEOUT-1, next state = FAIL.
  - PASS has priority if both conditions hold on the same edge.
- Latency:
  - The last channel reaching TARGET is visible on done_ch on edge N.
  - passed = 1 after edge N+1, i.e. one cycle later.
  - With no channel completing, failed = 1 exactly TIMEOUT+1 cycles after the start edge. That is the IDLE->RUN edge plus TIMEOUT RUN cycles.
- PASS and FAIL:
  - Terminal states; counters and done_ch are frozen.
  - inc and start are ignored.
  - Exit is only via clear or reset.
- start while in RUN, PASS or FAIL: ignored, no restart.
- NCH = 1 degenerates to a single-channel monitor with identical timing.

Test Plan:
- Reset then start, pulse inc = 2'b11 every cycle, NCH = 2, TARGET = 5 -> done_ch = 2'b11 on the 5th inc edge, passed = 1 one cycle later, count = {5,5} frozen, failed = 0 throughout.
- Channel 0 at 1 inc/cycle, channel 1 at 1 inc per 3 cycles -> done_ch = 2'b01 after 5 incs, 2'b11 after channel 1's 5th inc, passed follows by one cycle, final count_0 > 5.
- TIMEOUT = 20, only channel 0 incremented -> failed = 1 exactly 21 cycles after start, passed = 0, done_ch = 2'b01.
- WIDTH = 3, TARGET = 5, run 10 incs on channel 0 -> with SATURATE = 1 count_0 holds at 7; with SATURATE = 0 count_0 wraps to 2; done_ch[0] stays 1 in both.
- Assert reset asynchronously mid-RUN at count = {3,2} -> all outputs 0 and state IDLE before the next edge; inc ignored until a new start.
- In PASS, drive clear and start together -> IDLE, all counters 0, busy = 0; a start on the following cycle enters RUN normally.
